apb_master1: RTL and testbench
==============================

# apb_master1

APB requester (master) that converts a simple valid/ready command port into APB SETUP/ACCESS transfers and returns read data and error status on a one-cycle response strobe. It drives the bus side that our APB slaves (8-bit address, 8-bit data memory slaves) respond to. It sits between a local controller or test sequencer and a single APB slave select.

## Interface
- DATA_WIDTH, 8, width of pwdata/prdata/cmd_wdata/rsp_rdata
- ADDR_WIDTH, 8, width of paddr/cmd_addr
- TIMEOUT_CYCLES, 16, ACCESS wait cycles before abort (used only with APB_MASTER1_TIMEOUT_EN)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  one-cycle completion strobe
- rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid on reads
- rsp_err  output  1  pslverr (or timeout) for the completed transfer
- psel, penable, pwrite  output  1  APB control
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB error, sampled only with pready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On cmd_valid, capture write/addr/wdata into paddr/pwrite/pwdata and go to SETUP. Otherwise stay.
- SETUP: psel=1, penable=0, cmd_ready=0. Always go to ACCESS after exactly one cycle.
- ACCESS: psel=1, penable=1, cmd_ready=0. Hold paddr/pwrite/pwdata stable. On pready=1, go to IDLE. On that same edge, register rsp_valid=1 and rsp_err=pslverr. On reads, also register rsp_rdata=prdata. On pready=0, stay in ACCESS.
- rsp_rdata holds its last value on writes and between responses. rsp_valid is high for exactly one cycle per transfer.
- No response backpressure. The consumer must accept rsp_valid in the cycle it is high.
- paddr/pwdata/pwrite hold their last values in IDLE. psel=0 and penable=0 in IDLE.
- Reset (any state): next edge forces IDLE. psel, penable, pwrite, rsp_valid and rsp_err go to 0. paddr, pwdata and rsp_rdata go to 0. Any in-flight transfer is dropped and produces no response.

## Timing
- Zero-wait transfer:
  - Cycle 0: IDLE, handshake.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS with pready=1.
  - Cycle 3: IDLE with rsp_valid=1.
- Latency from handshake to rsp_valid is 3 cycles, plus N for N wait cycles (pready=0 in ACCESS).
- Back-to-back: in the rsp_valid cycle the FSM is in IDLE with cmd_ready=1. A command presented then is accepted, giving 3 cycles per zero-wait transfer.
- Command inputs are sampled only on the handshake edge. Changes at other times have no effect.
- pready and pslverr are ignored outside ACCESS.

## Configuration
- APB_MASTER1_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0, the FSM goes to IDLE, psel/penable drop, and rsp_valid=1 with rsp_err=1. rsp_rdata is unchanged.
  - If pready=1 arrives in the same cycle the count reaches the limit, pready wins and the transfer completes normally.
  - The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and resets to 0.
- Not defined: no counter logic. ACCESS waits indefinitely for pready.

## Structure
- Package apb_pkg holds:
  - state encoding localparams IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2
  - default DATA_WIDTH/ADDR_WIDTH constants, shared with the APB slaves
- Sub-module apb_master1_timeout: the wait-state counter with inputs clk, rst, start, pready and output expired. It is instantiated only under APB_MASTER1_TIMEOUT_EN.

## Test plan
- Write A=0x12 D=0x5A, slave pready=1 in the first ACCESS cycle -> psel high 2 cycles, penable high 1 cycle, pwdata=0x5A. rsp_valid 3 cycles after handshake, rsp_err=0.
- Read A=0x12 with 2 wait cycles, then prdata=0x5A with pready -> rsp_valid 5 cycles after handshake, rsp_rdata=0x5A. paddr stable throughout ACCESS.
- Two writes issued back-to-back -> second handshake in the rsp_valid cycle of the first. 6 cycles total, penable drops between transfers.
- Read with pslverr=1 and prdata=0xFF -> rsp_err=1 and rsp_rdata=0xFF for one cycle.
- TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_valid=1, rsp_err=1, back in IDLE.
- rst=1 during ACCESS -> next cycle psel=0, penable=0, cmd_ready=1, and no rsp_valid for the aborted transfer.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared APB definitions: FSM state encoding for the APB
//                requester and the default bus widths used by the APB
//                memory slaves on the same bus.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_pkg;

    // Default bus widths shared with the 8-bit address / 8-bit data slaves
    localparam int APB_DATA_WIDTH = 8;
    localparam int APB_ADDR_WIDTH = 8;

    // Requester FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETUP  = SETUP,
        ST_ACCESS = ACCESS
    } state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master1_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master1_timeout
//  Description : ACCESS-phase wait-state counter. Armed by start (asserted in
//                SETUP), it counts ACCESS cycles with pready low and flags
//                expired in the ACCESS cycle where the count reaches
//                TIMEOUT_CYCLES while pready is still low. A pready in that
//                same cycle suppresses expired, so a late ready still wins.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                start        - high in SETUP; clears and arms the counter
//                pready       - APB ready from the slave
//                expired      - abort request for the current ACCESS cycle
//  Revision    : 1.0  initial release
// ============================================================================
module apb_master1_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pready,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_active;   // high while the transfer is in ACCESS

    // This cycle's wait would bring the count up to the limit
    assign expired = r_active && !pready &&
                     (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_count  <= '0;
        end else if (r_active) begin
            if (pready || expired) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule : apb_master1_timeout
`default_nettype wire

// File: rtl/apb_master1.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master1
//  Description : APB requester. Turns a valid/ready command into an APB
//                SETUP/ACCESS transfer and reports completion on a one-cycle
//                rsp_valid strobe with read data and error status.
//                Optional ACCESS timeout: define APB_MASTER1_TIMEOUT_EN.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                cmd_valid/cmd_ready            - command handshake
//                cmd_write/cmd_addr/cmd_wdata   - command payload
//                rsp_valid/rsp_rdata/rsp_err    - completion strobe and status
//                psel/penable/pwrite/paddr/pwdata - APB request side
//                prdata/pready/pslverr          - APB completion side
//  Revision    : 1.0  initial release
// ============================================================================
module apb_master1
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // Command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // Response port
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    state_t r_state;
    state_t w_next_state;
    logic   w_expired;
    logic   w_done;

`ifdef APB_MASTER1_TIMEOUT_EN
    apb_master1_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .start   (r_state == ST_SETUP),
        .pready  (pready),
        .expired (w_expired)
    );
`else
    // No timeout hardware: ACCESS waits for pready indefinitely. The
    // comparison is constant false for any legal TIMEOUT_CYCLES.
    assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

    // Transfer finishes this cycle: slave ready, or the wait limit ran out
    assign w_done = (r_state == ST_ACCESS) && (pready || w_expired);

    // Next state and bus control
    always_comb begin
        w_next_state = r_state;
        psel         = 1'b0;
        penable      = 1'b0;
        cmd_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel         = 1'b1;
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (w_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            r_state <= w_next_state;

            // Command is sampled only on the handshake edge; the APB
            // request fields then hold until the next accepted command.
            if (r_state == ST_IDLE && cmd_valid) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
            end

            rsp_valid <= w_done;
            // A timeout reports an error; otherwise pslverr qualified by pready
            rsp_err   <= w_done && (pready ? pslverr : 1'b1);

            // Read data is captured only on a real read completion
            if (r_state == ST_ACCESS && pready && !pwrite) begin
                rsp_rdata <= prdata;
            end
        end
    end

endmodule : apb_master1
`default_nettype wire

// File: tb/tb_apb_master1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master1
//  Description : Directed self-checking bench for apb_master1. The APB slave
//                is modelled directly by driving pready/prdata/pslverr.
//                Timeout scenario runs when APB_MASTER1_TIMEOUT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_master1;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int tests_run    = 0;
    int tests_failed = 0;

    apb_master1 #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'hC3;
        cmd_wdata = 8'h3C;
        step();
        step();
        if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err} !== 6'b000100) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err}, 6'b000100);
        end
        tests_run++;
        if ({paddr, pwdata, rsp_rdata} !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected %h", {paddr, pwdata, rsp_rdata}, 24'h0);
        end
        tests_run++;
        rst       = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h12;
        cmd_wdata = 8'h5A;
        pready    = 1'b1;           // must be ignored in IDLE and SETUP
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_ready_idle: got %b expected 1", cmd_ready);
        end
        tests_run++;
        step();                     // cycle 1: SETUP
        cmd_valid = 1'b0;
        cmd_write = 1'b0;           // post-handshake changes must not leak
        cmd_addr  = 8'h34;
        cmd_wdata = 8'hA5;
        if ({psel, penable, cmd_ready, pwrite, paddr, pwdata} !== {4'b1001, 8'h12, 8'h5A}) begin
            tests_failed++;
            $display("FAIL wr_setup: got %b_%h_%h expected 1001_12_5a",
                     {psel, penable, cmd_ready, pwrite}, paddr, pwdata);
        end
        tests_run++;
        step();                     // cycle 2: ACCESS, pready=1
        if ({psel, penable, rsp_valid, pwrite, paddr, pwdata} !== {4'b1101, 8'h12, 8'h5A}) begin
            tests_failed++;
            $display("FAIL wr_access: got %b_%h_%h expected 1101_12_5a",
                     {psel, penable, rsp_valid, pwrite}, paddr, pwdata);
        end
        tests_run++;
        step();                     // cycle 3: IDLE, response
        if ({psel, penable, cmd_ready, rsp_valid, rsp_err, paddr} !== {5'b00110, 8'h12}) begin
            tests_failed++;
            $display("FAIL wr_rsp: got %b_%h expected 00110_12",
                     {psel, penable, cmd_ready, rsp_valid, rsp_err}, paddr);
        end
        tests_run++;
        step();
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wr_rsp_one_cycle: got %b expected 0", rsp_valid);
        end
        tests_run++;
        pready = 1'b0;
    endtask

    task automatic test_read_wait();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h12;
        pready    = 1'b0;
        prdata    = 8'hEE;
        step();                     // cycle 1: SETUP
        cmd_valid = 1'b0;
        cmd_addr  = 8'h99;
        step();                     // cycle 2: ACCESS wait
        for (int i = 0; i < 2; i++) begin
            if ({penable, rsp_valid, pwrite, paddr} !== {3'b100, 8'h12}) begin
                tests_failed++;
                $display("FAIL rd_wait%0d: got %b_%h expected 100_12",
                         i, {penable, rsp_valid, pwrite}, paddr);
            end
            tests_run++;
            step();
        end
        pready = 1'b1;              // cycle 4: ACCESS with ready
        prdata = 8'h5A;
        if ({penable, rsp_valid, paddr} !== {2'b10, 8'h12}) begin
            tests_failed++;
            $display("FAIL rd_ready_cycle: got %b_%h expected 10_12", {penable, rsp_valid}, paddr);
        end
        tests_run++;
        step();                     // cycle 5: response
        if ({rsp_valid, rsp_err, psel, rsp_rdata} !== {3'b100, 8'h5A}) begin
            tests_failed++;
            $display("FAIL rd_rsp: got %b_%h expected 100_5a", {rsp_valid, rsp_err, psel}, rsp_rdata);
        end
        tests_run++;
        pready = 1'b0;
        prdata = 8'h00;
        step();
        if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h5A}) begin
            tests_failed++;
            $display("FAIL rd_hold: got %b_%h expected 0_5a", rsp_valid, rsp_rdata);
        end
        tests_run++;
    endtask

    task automatic test_back_to_back();
        pready    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'h11;
        step();                     // cycle 1
        cmd_valid = 1'b0;
        step();                     // cycle 2: ACCESS
        if ({penable, pwdata} !== {1'b1, 8'h11}) begin
            tests_failed++;
            $display("FAIL b2b_first_access: got %b_%h expected 1_11", penable, pwdata);
        end
        tests_run++;
        step();                     // cycle 3: first response, issue second
        if ({rsp_valid, penable, cmd_ready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL b2b_gap: got %b expected 101", {rsp_valid, penable, cmd_ready});
        end
        tests_run++;
        cmd_valid = 1'b1;
        cmd_addr  = 8'h21;
        cmd_wdata = 8'h22;
        step();                     // cycle 4: SETUP of second
        cmd_valid = 1'b0;
        if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b100, 8'h21, 8'h22}) begin
            tests_failed++;
            $display("FAIL b2b_second_setup: got %b_%h_%h expected 100_21_22",
                     {psel, penable, rsp_valid}, paddr, pwdata);
        end
        tests_run++;
        step();                     // cycle 5
        step();                     // cycle 6: second response
        if ({rsp_valid, rsp_err, cmd_ready} !== 3'b101) begin
            tests_failed++;
            $display("FAIL b2b_second_rsp: got %b expected 101", {rsp_valid, rsp_err, cmd_ready});
        end
        tests_run++;
        pready = 1'b0;
        step();
    endtask

    task automatic test_slverr();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h30;
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 8'hFF;
        step();
        cmd_valid = 1'b0;
        step();
        step();                     // cycle 3: response
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 8'hFF}) begin
            tests_failed++;
            $display("FAIL err_rsp: got %b_%h expected 11_ff", {rsp_valid, rsp_err}, rsp_rdata);
        end
        tests_run++;
        step();                     // pslverr still high but we are in IDLE
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b00, 8'hFF}) begin
            tests_failed++;
            $display("FAIL err_one_cycle: got %b_%h expected 00_ff", {rsp_valid, rsp_err}, rsp_rdata);
        end
        tests_run++;
        // A write must leave rsp_rdata untouched even with prdata driven
        pslverr   = 1'b0;
        prdata    = 8'h00;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h31;
        cmd_wdata = 8'h77;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'hFF}) begin
            tests_failed++;
            $display("FAIL wr_keeps_rdata: got %b_%h expected 10_ff", {rsp_valid, rsp_err}, rsp_rdata);
        end
        tests_run++;
        pready = 1'b0;
        step();
    endtask

    task automatic test_reset_in_access();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h40;
        pready    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();                     // ACCESS
        if (penable !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_access: got %b expected 1", penable);
        end
        tests_run++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if ({psel, penable, cmd_ready, rsp_valid, paddr} !== {4'b0010, 8'h00}) begin
            tests_failed++;
            $display("FAIL rst_abort: got %b_%h expected 0010_00",
                     {psel, penable, cmd_ready, rsp_valid}, paddr);
        end
        tests_run++;
        pready = 1'b1;              // late ready must not resurrect the transfer
        for (int i = 0; i < 2; i++) begin
            step();
            if ({rsp_valid, psel} !== 2'b00) begin
                tests_failed++;
                $display("FAIL rst_no_rsp%0d: got %b expected 00", i, {rsp_valid, psel});
            end
            tests_run++;
        end
        pready = 1'b0;
    endtask

`ifdef APB_MASTER1_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h50;
        pready    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();                     // first ACCESS cycle
        while (penable === 1'b1 && n < 20) begin
            n++;
            step();
        end
        if (n !== TO) begin
            tests_failed++;
            $display("FAIL to_access_cycles: got %0d expected %0d", n, TO);
        end
        tests_run++;
        // rsp_rdata was last cleared by the reset scenario
        if ({rsp_valid, rsp_err, psel, cmd_ready, rsp_rdata} !== {4'b1101, 8'h00}) begin
            tests_failed++;
            $display("FAIL to_rsp: got %b_%h expected 1101_00",
                     {rsp_valid, rsp_err, psel, cmd_ready}, rsp_rdata);
        end
        tests_run++;
        step();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_back_to_back();
        test_slverr();
        test_reset_in_access();
`ifdef APB_MASTER1_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_apb_master1
`default_nettype wire
